// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  localparam logic [7:0] KEY_SPACE     = 8'd32;
  localparam logic [7:0] KEY_NEWLINE   = 8'd128;
  localparam logic [7:0] KEY_BACKSPACE = 8'd129;
  localparam logic [7:0] KEY_LEFT      = 8'd130;
  localparam logic [7:0] KEY_UP        = 8'd131;
  localparam logic [7:0] KEY_RIGHT     = 8'd132;
  localparam logic [7:0] KEY_DOWN      = 8'd133;
  localparam logic [7:0] KEY_HOME      = 8'd134;
  localparam logic [7:0] KEY_END       = 8'd135;
  localparam logic [7:0] KEY_PGUP      = 8'd136;
  localparam logic [7:0] KEY_PGDN      = 8'd137;
  localparam logic [7:0] KEY_INS       = 8'd138;
  localparam logic [7:0] KEY_DEL       = 8'd139;
  localparam logic [7:0] KEY_ESC       = 8'd140;
  localparam logic [7:0] KEY_F1        = 8'd141;
  localparam logic [7:0] KEY_F12       = 8'd152;

endpackage

// File: rtl/ps2_to_hack_decode.sv
// Scan-code set 2 byte plus E0 flag to Hack key code.
module ps2_to_hack_decode
  import kbd_pkg::*;
(
  input  logic [7:0]  scan,
  input  logic        ext,
  output logic [15:0] code
);

  logic [7:0] k;

  always_comb begin
    k = 8'd0;
    if (ext) begin
      case (scan)
        8'h6B:   k = KEY_LEFT;
        8'h75:   k = KEY_UP;
        8'h74:   k = KEY_RIGHT;
        8'h72:   k = KEY_DOWN;
        8'h6C:   k = KEY_HOME;
        8'h69:   k = KEY_END;
        8'h7D:   k = KEY_PGUP;
        8'h7A:   k = KEY_PGDN;
        8'h70:   k = KEY_INS;
        8'h71:   k = KEY_DEL;
        default: k = 8'd0;
      endcase
    end else begin
      case (scan)
        8'h1C: k = "A";
        8'h32: k = "B";
        8'h21: k = "C";
        8'h23: k = "D";
        8'h24: k = "E";
        8'h2B: k = "F";
        8'h34: k = "G";
        8'h33: k = "H";
        8'h43: k = "I";
        8'h3B: k = "J";
        8'h42: k = "K";
        8'h4B: k = "L";
        8'h3A: k = "M";
        8'h31: k = "N";
        8'h44: k = "O";
        8'h4D: k = "P";
        8'h15: k = "Q";
        8'h2D: k = "R";
        8'h1B: k = "S";
        8'h2C: k = "T";
        8'h3C: k = "U";
        8'h2A: k = "V";
        8'h1D: k = "W";
        8'h22: k = "X";
        8'h35: k = "Y";
        8'h1A: k = "Z";
        8'h45: k = "0";
        8'h16: k = "1";
        8'h1E: k = "2";
        8'h26: k = "3";
        8'h25: k = "4";
        8'h2E: k = "5";
        8'h36: k = "6";
        8'h3D: k = "7";
        8'h3E: k = "8";
        8'h46: k = "9";
        8'h29: k = KEY_SPACE;
        8'h5A: k = KEY_NEWLINE;
        8'h66: k = KEY_BACKSPACE;
        8'h76: k = KEY_ESC;
        8'h05: k = KEY_F1;
        8'h06: k = KEY_F1 + 8'd1;
        8'h04: k = KEY_F1 + 8'd2;
        8'h0C: k = KEY_F1 + 8'd3;
        8'h03: k = KEY_F1 + 8'd4;
        8'h0B: k = KEY_F1 + 8'd5;
        8'h83: k = KEY_F1 + 8'd6;
        8'h0A: k = KEY_F1 + 8'd7;
        8'h01: k = KEY_F1 + 8'd8;
        8'h09: k = KEY_F1 + 8'd9;
        8'h78: k = KEY_F1 + 8'd10;
        8'h07: k = KEY_F12;
        default: k = 8'd0;
      endcase
    end
  end

  assign code = {8'h00, k};

endmodule

// File: rtl/kbd_ps2_receiver.sv
// PS/2 device-to-host receiver driving the Hack KBD register.
// Build option: PS2_PARITY_CHECK_EN rejects frames with bad odd parity.
module kbd_ps2_receiver
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] out,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        frame_err
);

  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SS-1:0] clk_sync;
  logic [SS-1:0] dat_sync;
  logic          clk_prev;
  logic          clk_s;
  logic          dat_s;
  logic          fall;

  ps2_state_t    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          e0_seen;
  logic          f0_seen;
  logic          parity_ok;
  logic [15:0]   code;

  assign clk_s   = clk_sync[SS-1];
  assign dat_s   = dat_sync[SS-1];
  assign fall    = clk_prev & ~clk_s;
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^{shift, par};
`else
  assign parity_ok = 1'b1;
`endif

  ps2_to_hack_decode u_dec (
    .scan (shift),
    .ext  (e0_seen),
    .code (code)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SS-2:0], ps2_clk};
      dat_sync <= {dat_sync[SS-2:0], ps2_data};
      clk_prev <= clk_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shift      <= 8'h00;
      par        <= 1'b0;
      tmo_cnt    <= '0;
      e0_seen    <= 1'b0;
      f0_seen    <= 1'b0;
      out        <= 16'h0000;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == IDLE) begin
        tmo_cnt <= '0;
        if (fall && !dat_s) begin
          state   <= DATA;
          bit_cnt <= 3'd0;
        end
      end else if (fall) begin
        tmo_cnt <= '0;
        unique case (state)
          DATA: begin
            shift   <= {dat_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= dat_s;
            state <= STOP;
          end
          default: begin
            state <= IDLE;
            if (dat_s && parity_ok) begin
              byte_valid <= 1'b1;
              byte_data  <= shift;
              if (shift == SC_EXT) begin
                e0_seen <= 1'b1;
              end else if (shift == SC_BREAK) begin
                f0_seen <= 1'b1;
              end else begin
                e0_seen <= 1'b0;
                f0_seen <= 1'b0;
                // Break only clears the key that is currently shown.
                if (f0_seen) begin
                  if (code == out) out <= 16'h0000;
                end else if (code != 16'h0000) begin
                  out <= code;
                end
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
        endcase
      end else if (tmo_hit) begin
        state     <= IDLE;
        tmo_cnt   <= '0;
        frame_err <= 1'b1;
      end else begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_kbd_ps2_receiver.sv
// Scoreboard bench for kbd_ps2_receiver.
module tb_kbd_ps2_receiver;

  localparam int TO   = 200;
  localparam int HALF = 20;

  typedef struct {
    logic        err;
    logic [7:0]  b;
    logic [15:0] o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] out;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_err;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  kbd_ps2_receiver #(
    .TIMEOUT_CYCLES (TO),
    .SYNC_STAGES    (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .out        (out),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (byte_valid || frame_err) begin
      if (q.size() == 0) begin
        chk("unexpected_event", {30'd0, byte_valid, frame_err}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("kind_err", {31'd0, frame_err}, {31'd0, e.err});
        chk("kind_valid", {31'd0, byte_valid}, {31'd0, ~e.err});
        if (!e.err) chk("byte_data", {24'd0, byte_data}, {24'd0, e.b});
        chk("out", {16'd0, out}, {16'd0, e.o});
      end
    end
  end

  function automatic logic [10:0] mk(input logic [7:0] b, input logic pbad,
                                     input logic stp);
    return {stp, (~^b) ^ pbad, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (HALF) @(posedge clk);
  endtask

  task automatic push(input logic err, input logic [7:0] b,
                      input logic [15:0] o);
    exp_t e;
    e.err = err;
    e.b   = b;
    e.o   = o;
    q.push_back(e);
  endtask

  task automatic sendb(input logic [7:0] b, input logic [15:0] o);
    push(1'b0, b, o);
    send_bits(mk(b, 1'b0, 1'b1), 11);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] po;
    repeat (3) @(negedge clk);
    chk("rst_out", {16'd0, out}, 32'd0);
    chk("rst_valid", {31'd0, byte_valid}, 32'd0);
    chk("rst_err", {31'd0, frame_err}, 32'd0);
    chk("rst_byte", {24'd0, byte_data}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    sendb(8'h1C, 16'd65);
    sendb(8'hF0, 16'd65);
    sendb(8'h1C, 16'd0);

    sendb(8'hE0, 16'd0);
    sendb(8'h6B, 16'd130);
    sendb(8'hE0, 16'd130);
    sendb(8'hF0, 16'd130);
    sendb(8'h6B, 16'd0);
    sendb(8'hF0, 16'd0);
    sendb(8'h29, 16'd0);

    sendb(8'h1C, 16'd65);
    sendb(8'h32, 16'd66);
    sendb(8'hF0, 16'd66);
    sendb(8'h1C, 16'd66);
    sendb(8'hF0, 16'd66);
    sendb(8'h32, 16'd0);

`ifdef PS2_PARITY_CHECK_EN
    push(1'b1, 8'h00, 16'd0);
    po = 16'd0;
`else
    push(1'b0, 8'h1C, 16'd65);
    po = 16'd65;
`endif
    send_bits(mk(8'h1C, 1'b1, 1'b1), 11);
    sendb(8'hF0, po);
    sendb(8'h1C, 16'd0);

    push(1'b1, 8'h00, 16'd0);
    send_bits(mk(8'h1C, 1'b0, 1'b1), 5);
    repeat (TO + 100) @(posedge clk);
    sendb(8'h29, 16'd32);
    push(1'b1, 8'h00, 16'd32);
    send_bits(mk(8'h29, 1'b0, 1'b0), 11);

    send_bits(mk(8'h5A, 1'b0, 1'b1), 5);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_out", {16'd0, out}, 32'd0);
    chk("mid_rst_valid", {31'd0, byte_valid}, 32'd0);
    chk("mid_rst_err", {31'd0, frame_err}, 32'd0);
    chk("mid_rst_byte", {24'd0, byte_data}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    sendb(8'h5A, 16'd128);

    for (int i = 0; i < 2000 && q.size() != 0; i++) @(posedge clk);
    repeat (TO + 50) @(posedge clk);
    @(negedge clk);
    chk("drain", q.size(), 32'd0);
    chk("final_out", {16'd0, out}, 32'd128);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kbd_ps2_receiver.md
Name: kbd_ps2_receiver

Overview:
- Receiver end of the PS/2 keyboard link, on the device-to-host direction.
- Deserialises PS/2 scan-code frames and tracks make/break codes.
- Drives the 16-bit Hack keyboard register: the memory-mapped KBD word at 24576 that the CPU reads.
- Output holds the Hack key code of the key currently down, or 0 when no key is down.

Parameters:
- TIMEOUT_CYCLES, 50000: clk cycles without a PS/2 falling edge mid-frame before the frame is abandoned.
- SYNC_STAGES, 2: flip-flop depth of the ps2_clk/ps2_data synchronisers (minimum 2).

Ports:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock from the keyboard; asynchronous.
- ps2_data  in  1  raw PS/2 data from the keyboard; asynchronous.
- out  out  16  Hack keyboard register value.
- byte_valid  out  1  one-cycle pulse when a frame is accepted.
- byte_data  out  8  last accepted scan byte; valid while byte_valid is high, held otherwise.
- frame_err  out  1  one-cycle pulse when a frame is rejected.

Behaviour:
- Reset values: out=0, byte_valid=0, byte_data=0x00, frame_err=0, FSM=IDLE, e0_seen=0, f0_seen=0, synchronisers=1.
- Reset mid-frame discards the partial frame; no pulse is produced.
- Inputs pass through SYNC_STAGES flops. A falling edge is a synced ps2_clk 1->0 transition. All sampling happens on falling edges only.
- Frame format: start(0), 8 data bits LSB first, odd parity, stop(1).
- FSM states:
  - IDLE: on an edge with data=0, go to DATA and set bit count=0. Data=1 at an edge is ignored (no error).
  - DATA: shift 8 bits, then go to PARITY.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP: if stop=1 and parity passes, accept the byte; otherwise pulse frame_err. Return to IDLE either way.
- Timeout: in DATA/PARITY/STOP a cycle counter resets on every edge. When it reaches TIMEOUT_CYCLES: pulse frame_err, return to IDLE, discard the partial byte.
- Byte acceptance: byte_valid pulses exactly 1 cycle after the clk edge that detects the stop-bit falling edge.
- Accepted-byte handling:
  - 0xE0 sets e0_seen.
  - 0xF0 sets f0_seen.
  - Any other byte is decoded with e0_seen, then clears both flags.
- Make (f0_seen=0): if the decoded code is nonzero, out <= code. Unmapped codes leave out unchanged. Typematic repeats rewrite the same value.
- Break (f0_seen=1): if the decoded code equals out, out <= 0. Otherwise out is unchanged, so releasing a non-latest key keeps the latest key visible.
- Rejected frames leave out, e0_seen and f0_seen unchanged.
- out updates in the same cycle byte_valid is asserted.
- Decode set (standard Hack codes):
  - A-Z → 65-90; 0-9 → 48-57; space → 32.
  - enter → 128; backspace → 129; esc → 140; F1-F12 → 141-152.
  - E0-prefixed: left 130, up 131, right 132, down 133, home 134, end 135, pgup 136, pgdn 137, ins 138, del 139.
- Upper out bits [15:8] are always 0.

Optional Feature:
- Macro PS2_PARITY_CHECK_EN.
- Defined: a parity mismatch (data ones + parity bit even) rejects the frame with a frame_err pulse.
- Undefined: the parity bit is sampled but ignored. Only start/stop/timeout errors raise frame_err.

Decomposition:
- Package kbd_pkg:
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - Prefix constants SC_EXT=0xE0, SC_BREAK=0xF0.
  - Hack key-code constants (KEY_NEWLINE=128, KEY_BACKSPACE=129, KEY_LEFT=130 … KEY_F12=152).
- Sub-module ps2_to_hack_decode: combinational scan byte + ext flag → 16-bit Hack code, 0 if unmapped. Verified standalone.

Test Plan:
- Frame 0x1C, parity 0 → byte_valid pulse, byte_data=0x1C, out=65. Then F0,1C → out=0.
- E0,6B → out=130. Then E0,F0,6B → out=0. A stray F0 followed by 0x29 is a break of space; out stays 0.
- Press 0x1C (out=65), press 0x32 (out=66), release 0x1C → out stays 66. Release 0x32 → out=0.
- Frame 0x1C with parity=1:
  - With PS2_PARITY_CHECK_EN: frame_err pulse, no byte_valid, out unchanged.
  - Without it: out=65.
- Five bits, then clk idle for TIMEOUT_CYCLES → frame_err pulse, FSM IDLE. Next clean 0x29 → out=32. A stop bit of 0 → frame_err.
- Assert rst_n=0 mid-frame after 4 bits, release, send 0x5A → no frame_err, out=128, all outputs zero during reset.
